// File: rtl/fire7_expand1_layer.sv
// fire7 expand1x1: streamed 1x1 convolution, DSP_NO parallel MACs, per-channel bias, Q2.14 requantise.
// Optional ReLU clamp when FIRE7_EXPAND1_RELU_EN is defined; ROM images come from the *_BASE/*_XOR_MASK parameters.
module fire7_expand1_layer #(
    parameter int unsigned      WOUT            = 16,
    parameter int unsigned      DSP_NO          = 192,
    parameter int unsigned      WIDTH           = 16,
    parameter int unsigned      CHIN            = 64,
    parameter int unsigned      KDIM            = 1,
    parameter logic [WIDTH-1:0] WEIGHT_BASE     = WIDTH'(16'h4000),
    parameter logic [WIDTH-1:0] WEIGHT_XOR_MASK = '0,
    parameter logic [31:0]      BIAS_BASE       = 32'h0000_0000,
    parameter logic [31:0]      BIAS_XOR_MASK   = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] ifm_i,
    input  logic             ram_feedback,
    output logic             sample,
    output logic [WIDTH-1:0] ofm [DSP_NO],
    output logic             layer_done,
    output logic             ram_ack
);
    localparam int unsigned N      = KDIM * KDIM * CHIN;
    localparam int unsigned NPIX   = WOUT * WOUT;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned FRAC   = WIDTH - 2;
    localparam int unsigned HI_W   = ACC_W - FRAC - WIDTH;
    localparam int unsigned BEAT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PIX_W  = $clog2(NPIX + 1);

    // Weight image: word for beat a, channel ch sits at flat address a*DSP_NO+ch.
    function automatic logic [WIDTH-1:0] rom_weight(input logic [BEAT_W-1:0] beat, input int unsigned ch);
        rom_weight = WEIGHT_BASE ^ (WEIGHT_XOR_MASK & WIDTH'(32'(beat) * DSP_NO + ch));
    endfunction

    function automatic logic [ACC_W-1:0] rom_bias(input int unsigned ch);
        rom_bias = BIAS_BASE ^ (BIAS_XOR_MASK & ch);
    endfunction

    // Q4.28 sum down to Q2.14; the two integer bits above the kept range are dropped unsaturated.
    function automatic logic [WIDTH-1:0] requant(input logic sign, input logic [WIDTH-2:0] mag);
`ifdef FIRE7_EXPAND1_RELU_EN
        requant = sign ? '0 : {1'b0, mag};
`else
        requant = {sign, mag};
`endif
    endfunction

    logic                accept;
    logic [ACC_W-1:0]    sum_c;
    logic [HI_W-1:0]     unused_sum_bits;

    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic                s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]    s1_ifm_q, s1_ifm_d;
    logic [BEAT_W-1:0]   s1_beat_q, s1_beat_d;
    logic                s2_valid_q, s2_valid_d;
    logic                s2_first_q, s2_first_d;
    logic                s2_last_q, s2_last_d;
    logic [WIDTH-1:0]    s2_ifm_q, s2_ifm_d;
    logic [WIDTH-1:0]    w_q [DSP_NO];
    logic [WIDTH-1:0]    w_d [DSP_NO];
    logic                s3_valid_q, s3_valid_d;
    logic                s3_first_q, s3_first_d;
    logic                s3_last_q, s3_last_d;
    logic [ACC_W-1:0]    prod_q [DSP_NO];
    logic [ACC_W-1:0]    prod_d [DSP_NO];
    logic                s4_last_q, s4_last_d;
    logic [ACC_W-1:0]    acc_q [DSP_NO];
    logic [ACC_W-1:0]    acc_d [DSP_NO];
    logic [WIDTH-1:0]    ofm_q [DSP_NO];
    logic [WIDTH-1:0]    ofm_d [DSP_NO];
    logic                sample_q, sample_d;
    logic                layer_done_q, layer_done_d;
    logic                ram_ack_q, ram_ack_d;

    // Pipeline: capture -> ROM read -> multiply -> accumulate -> bias/requantise.
    always_comb begin
        accept          = en_i && !layer_done_q;
        beat_d          = beat_q;
        s1_valid_d      = accept;
        s1_ifm_d        = ifm_i;
        s1_beat_d       = beat_q;
        s2_valid_d      = s1_valid_q;
        s2_ifm_d        = s1_ifm_q;
        s2_first_d      = (s1_beat_q == '0);
        s2_last_d       = (s1_beat_q == BEAT_W'(N - 1));
        s3_valid_d      = s2_valid_q;
        s3_first_d      = s2_first_q;
        s3_last_d       = s2_last_q;
        s4_last_d       = s3_valid_q && s3_last_q;
        sample_d        = s4_last_q;
        pix_d           = pix_q;
        layer_done_d    = layer_done_q;
        ram_ack_d       = ram_ack_q | ram_feedback;
        sum_c           = '0;
        unused_sum_bits = '0;

        if (accept) begin
            beat_d = (beat_q == BEAT_W'(N - 1)) ? '0 : beat_q + BEAT_W'(1);
        end

        for (int unsigned i = 0; i < DSP_NO; i++) begin
            w_d[i]    = rom_weight(s1_beat_q, i);
            prod_d[i] = ACC_W'(signed'(s2_ifm_q)) * ACC_W'(signed'(w_q[i]));
            acc_d[i]  = acc_q[i];
            ofm_d[i]  = ofm_q[i];
            if (s3_valid_q) begin
                acc_d[i] = s3_first_q ? prod_q[i] : acc_q[i] + prod_q[i];
            end
            sum_c           = acc_q[i] + rom_bias(i);
            unused_sum_bits = unused_sum_bits ^ sum_c[ACC_W-2:FRAC+WIDTH-1];
            if (s4_last_q) begin
                ofm_d[i] = requant(sum_c[ACC_W-1], sum_c[FRAC+WIDTH-2:FRAC]);
            end
        end

        if (s4_last_q) begin
            pix_d = pix_q + PIX_W'(1);
            if (pix_q == PIX_W'(NPIX - 1)) begin
                layer_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q       <= '0;
            pix_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_ifm_q     <= '0;
            s1_beat_q    <= '0;
            s2_valid_q   <= 1'b0;
            s2_first_q   <= 1'b0;
            s2_last_q    <= 1'b0;
            s2_ifm_q     <= '0;
            s3_valid_q   <= 1'b0;
            s3_first_q   <= 1'b0;
            s3_last_q    <= 1'b0;
            s4_last_q    <= 1'b0;
            sample_q     <= 1'b0;
            layer_done_q <= 1'b0;
            ram_ack_q    <= 1'b0;
            for (int unsigned i = 0; i < DSP_NO; i++) begin
                w_q[i]    <= '0;
                prod_q[i] <= '0;
                acc_q[i]  <= '0;
                ofm_q[i]  <= '0;
            end
        end else begin
            beat_q       <= beat_d;
            pix_q        <= pix_d;
            s1_valid_q   <= s1_valid_d;
            s1_ifm_q     <= s1_ifm_d;
            s1_beat_q    <= s1_beat_d;
            s2_valid_q   <= s2_valid_d;
            s2_first_q   <= s2_first_d;
            s2_last_q    <= s2_last_d;
            s2_ifm_q     <= s2_ifm_d;
            s3_valid_q   <= s3_valid_d;
            s3_first_q   <= s3_first_d;
            s3_last_q    <= s3_last_d;
            s4_last_q    <= s4_last_d;
            sample_q     <= sample_d;
            layer_done_q <= layer_done_d;
            ram_ack_q    <= ram_ack_d;
            for (int unsigned i = 0; i < DSP_NO; i++) begin
                w_q[i]    <= w_d[i];
                prod_q[i] <= prod_d[i];
                acc_q[i]  <= acc_d[i];
                ofm_q[i]  <= ofm_d[i];
            end
        end
    end

    assign sample     = sample_q;
    assign ofm        = ofm_q;
    assign layer_done = layer_done_q;
    assign ram_ack    = ram_ack_q;

endmodule

// File: tb/tb_fire7_expand1_layer.sv
// Scoreboard bench for fire7_expand1_layer: three instances (unity ROM, negative bias, varied ROM) share one stimulus.
`timescale 1ns/1ps
module tb_fire7_expand1_layer;
    localparam int unsigned DSP_NO = 192;
    localparam int unsigned WIDTH  = 16;
    localparam int          N      = 64;
    localparam int          NPIX   = 256;
    localparam logic [15:0] WB_BASE = 16'h8A5C;
    localparam logic [15:0] WB_MASK = 16'hFFFF;
    localparam logic [31:0] BB_BASE = 32'h0123_4567;
    localparam logic [31:0] BB_MASK = 32'h0000_00FF;
    localparam logic [31:0] BC_BASE = 32'hE000_0000;

    typedef logic [DSP_NO*WIDTH-1:0] pix_t;
    typedef struct packed { pix_t a; pix_t b; pix_t c; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic ram_fb = 1'b0;
    logic [15:0] ifm = '0;
    logic sample_a, sample_b, sample_c;
    logic done_a, done_b, done_c;
    logic ack_a, ack_b, ack_c;
    logic [15:0] ofm_a [DSP_NO];
    logic [15:0] ofm_b [DSP_NO];
    logic [15:0] ofm_c [DSP_NO];
    pix_t got_a, got_b, got_c;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_samp = 0;
    int last_cyc = 0;
    int mbeat = 0;
    int mpix = 0;
    int acc_a [DSP_NO];
    int acc_b [DSP_NO];
    int acc_c [DSP_NO];
    exp_t exp_q [$];
    int   cyc_q [$];
    exp_t mon_e;

    fire7_expand1_layer dut_a (
        .clk(clk), .rst(rst), .en_i(en), .ifm_i(ifm), .ram_feedback(ram_fb),
        .sample(sample_a), .ofm(ofm_a), .layer_done(done_a), .ram_ack(ack_a));

    fire7_expand1_layer #(.WEIGHT_BASE(WB_BASE), .WEIGHT_XOR_MASK(WB_MASK),
                          .BIAS_BASE(BB_BASE), .BIAS_XOR_MASK(BB_MASK)) dut_b (
        .clk(clk), .rst(rst), .en_i(en), .ifm_i(ifm), .ram_feedback(ram_fb),
        .sample(sample_b), .ofm(ofm_b), .layer_done(done_b), .ram_ack(ack_b));

    fire7_expand1_layer #(.BIAS_BASE(BC_BASE)) dut_c (
        .clk(clk), .rst(rst), .en_i(en), .ifm_i(ifm), .ram_feedback(ram_fb),
        .sample(sample_c), .ofm(ofm_c), .layer_done(done_c), .ram_ack(ack_c));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < DSP_NO; i++) begin
            got_a[i*WIDTH +: WIDTH] = ofm_a[i];
            got_b[i*WIDTH +: WIDTH] = ofm_b[i];
            got_c[i*WIDTH +: WIDTH] = ofm_c[i];
        end
    end

    function automatic logic [15:0] w_of(input logic [15:0] base, input logic [15:0] mask, input int a, input int i);
        return base ^ (mask & 16'(a * DSP_NO + i));
    endfunction

    function automatic logic [15:0] rq(input logic [31:0] s);
`ifdef FIRE7_EXPAND1_RELU_EN
        return s[31] ? 16'h0000 : {1'b0, s[28:14]};
`else
        return {s[31], s[28:14]};
`endif
    endfunction

    function automatic int first_diff(input pix_t g, input pix_t e);
        for (int i = 0; i < DSP_NO; i++)
            if (g[i*WIDTH +: WIDTH] !== e[i*WIDTH +: WIDTH]) return i;
        return -1;
    endfunction

    task automatic model_beat(input logic [15:0] x);
        logic signed [15:0] xs;
        logic signed [15:0] ws;
        int xi, wi;
        exp_t e;
        if (mpix >= NPIX) return;
        xs = x;
        xi = xs;
        for (int i = 0; i < DSP_NO; i++) begin
            ws = 16'h4000;
            wi = ws;
            acc_a[i] = (mbeat == 0) ? xi * wi : acc_a[i] + xi * wi;
            acc_c[i] = (mbeat == 0) ? xi * wi : acc_c[i] + xi * wi;
            ws = w_of(WB_BASE, WB_MASK, mbeat, i);
            wi = ws;
            acc_b[i] = (mbeat == 0) ? xi * wi : acc_b[i] + xi * wi;
        end
        if (mbeat == N - 1) begin
            for (int i = 0; i < DSP_NO; i++) begin
                e.a[i*WIDTH +: WIDTH] = rq(32'(acc_a[i]));
                e.b[i*WIDTH +: WIDTH] = rq(32'(acc_b[i]) + (BB_BASE ^ (BB_MASK & 32'(i))));
                e.c[i*WIDTH +: WIDTH] = rq(32'(acc_c[i]) + BC_BASE);
            end
            exp_q.push_back(e);
            cyc_q.push_back(cyc + 5);
            mpix++;
            mbeat = 0;
        end else begin
            mbeat++;
        end
    endtask

    task automatic beat(input logic [15:0] x);
        @(negedge clk);
        en = 1'b1;
        ifm = x;
        last_cyc = cyc;
        model_beat(x);
    endtask

    task automatic idle();
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en = 1'b0;
        ram_fb = 1'b0;
        exp_q.delete();
        cyc_q.delete();
        mbeat = 0;
        mpix = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200 && exp_q.size() > 0; k++) idle();
        idle();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d pixels still pending, required 0", exp_q.size());
            exp_q.delete();
            cyc_q.delete();
        end
    endtask

    // Scoreboard: each expected pixel must appear exactly at its due cycle on all three instances.
    always @(negedge clk) begin
        if (sample_a) n_samp++;
        if (!rst && exp_q.size() > 0 && cyc == cyc_q[0]) begin
            mon_e = exp_q.pop_front();
            void'(cyc_q.pop_front());
            n_vec++;
            if ({sample_a, sample_b, sample_c} !== 3'b111) begin
                n_err++;
                $display("FAIL sample_timing cyc %0d: got %b required 111", cyc, {sample_a, sample_b, sample_c});
            end
            n_vec++;
            if (got_a !== mon_e.a) begin
                n_err++;
                $display("FAIL ofm_a ch %0d: got %h required %h", first_diff(got_a, mon_e.a),
                         ofm_a[first_diff(got_a, mon_e.a)], mon_e.a[first_diff(got_a, mon_e.a)*WIDTH +: WIDTH]);
            end
            n_vec++;
            if (got_b !== mon_e.b) begin
                n_err++;
                $display("FAIL ofm_b ch %0d: got %h required %h", first_diff(got_b, mon_e.b),
                         ofm_b[first_diff(got_b, mon_e.b)], mon_e.b[first_diff(got_b, mon_e.b)*WIDTH +: WIDTH]);
            end
            n_vec++;
            if (got_c !== mon_e.c) begin
                n_err++;
                $display("FAIL ofm_c ch %0d: got %h required %h", first_diff(got_c, mon_e.c),
                         ofm_c[first_diff(got_c, mon_e.c)], mon_e.c[first_diff(got_c, mon_e.c)*WIDTH +: WIDTH]);
            end
        end else if (sample_a || sample_b || sample_c) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_sample cyc %0d: got %b required 000", cyc, {sample_a, sample_b, sample_c});
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({sample_a, sample_b, sample_c} !== 3'b000) begin
            n_err++; $display("FAIL reset_sample: got %b required 000", {sample_a, sample_b, sample_c});
        end
        n_vec++;
        if ({done_a, done_b, done_c} !== 3'b000) begin
            n_err++; $display("FAIL reset_done: got %b required 000", {done_a, done_b, done_c});
        end
        n_vec++;
        if ({ack_a, ack_b, ack_c} !== 3'b000) begin
            n_err++; $display("FAIL reset_ack: got %b required 000", {ack_a, ack_b, ack_c});
        end
        n_vec++;
        if ((got_a | got_b | got_c) !== '0) begin
            n_err++; $display("FAIL reset_ofm: got nonzero ch0 %h/%h/%h required 0000", ofm_a[0], ofm_b[0], ofm_c[0]);
        end
    endtask

    task automatic test_unity();
        do_reset();
        for (int k = 0; k < N; k++) beat(16'h0100);
        wait_drain();
        n_vec++;
        if (got_a !== {DSP_NO{16'h4000}}) begin
            n_err++; $display("FAIL unity_value: got %h required 4000", ofm_a[first_diff(got_a, {DSP_NO{16'h4000}})]);
        end
`ifdef FIRE7_EXPAND1_RELU_EN
        n_vec++;
        if (got_c !== {DSP_NO{16'h0000}}) begin
            n_err++; $display("FAIL bias_relu: got %h required 0000", ofm_c[0]);
        end
`else
        n_vec++;
        if (got_c !== {DSP_NO{16'hC000}}) begin
            n_err++; $display("FAIL bias_passthru: got %h required c000", ofm_c[0]);
        end
`endif
    endtask

    task automatic test_gapped();
        do_reset();
        for (int k = 0; k < N; k++) begin
            beat(16'h0100);
            idle();
        end
        wait_drain();
        n_vec++;
        if (got_a !== {DSP_NO{16'h4000}}) begin
            n_err++; $display("FAIL gapped_value: got %h required 4000", ofm_a[0]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < N; k++) beat(16'h0100);
        for (int k = 0; k < N; k++) beat(16'h0200);
        wait_drain();
        n_vec++;
        if (got_a !== {DSP_NO{16'h0000}}) begin
            n_err++; $display("FAIL b2b_wrap_value: got %h required 0000", ofm_a[0]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < N; k++) begin
                beat(16'($urandom));
                if ($urandom_range(0, 3) == 0) idle();
            end
        end
        wait_drain();
    endtask

    task automatic test_mid_reset();
        int s0;
        do_reset();
        for (int k = 0; k < 30; k++) beat(16'h0300);
        do_reset();
        s0 = n_samp;
        for (int k = 0; k < N; k++) beat(16'h0100);
        wait_drain();
        repeat (8) idle();
        n_vec++;
        if (n_samp - s0 != 1) begin
            n_err++; $display("FAIL mid_reset_samples: got %0d required 1", n_samp - s0);
        end
        n_vec++;
        if (got_a !== {DSP_NO{16'h4000}}) begin
            n_err++; $display("FAIL mid_reset_value: got %h required 4000", ofm_a[0]);
        end
    endtask

    task automatic test_layer_end();
        int s0;
        do_reset();
        s0 = n_samp;
        for (int p = 0; p < NPIX; p++)
            for (int k = 0; k < N; k++) beat(16'($urandom));
        while (cyc < last_cyc + 4) idle();
        n_vec++;
        if ({done_a, done_b, done_c} !== 3'b000) begin
            n_err++; $display("FAIL done_early: got %b required 000", {done_a, done_b, done_c});
        end
        idle();
        n_vec++;
        if ({done_a, done_b, done_c} !== 3'b111) begin
            n_err++; $display("FAIL done_with_last_sample: got %b required 111", {done_a, done_b, done_c});
        end
        wait_drain();
        for (int k = 0; k < N; k++) beat(16'h0100);
        repeat (12) idle();
        n_vec++;
        if (n_samp - s0 != NPIX) begin
            n_err++; $display("FAIL layer_samples: got %0d required %0d", n_samp - s0, NPIX);
        end
        n_vec++;
        if ({ack_a, ack_b, ack_c} !== 3'b000) begin
            n_err++; $display("FAIL ack_before_pulse: got %b required 000", {ack_a, ack_b, ack_c});
        end
        @(negedge clk);
        ram_fb = 1'b1;
        @(negedge clk);
        ram_fb = 1'b0;
        repeat (5) idle();
        n_vec++;
        if ({ack_a, ack_b, ack_c} !== 3'b111) begin
            n_err++; $display("FAIL ack_sticky: got %b required 111", {ack_a, ack_b, ack_c});
        end
        do_reset();
        @(negedge clk);
        n_vec++;
        if ({ack_a, done_a, ack_b, done_b} !== 4'b0000) begin
            n_err++; $display("FAIL ack_done_cleared: got %b required 0000", {ack_a, done_a, ack_b, done_b});
        end
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL global_timeout: simulation time exhausted");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_unity();
        test_gapped();
        test_back_to_back();
        test_random();
        test_mid_reset();
        test_layer_end();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
